// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-beat valid/ready command port to APB requester with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_error_o,
  output logic              pselx_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverror_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  // A zero TIMEOUT still needs a 1-bit counter so the saturating logic stays well-formed.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic              expire;
  assign expire      = (TIMEOUT != 0) && (cnt_q == LAST);
  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rvalid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = rerr_q;
  assign pselx_o     = psel_q;
  assign penable_o   = pen_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  // Next-state: sequence IDLE -> SETUP -> ACCESS and build the response pulse on completion or abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d  = SETUP;
        psel_d   = 1'b1;
        pwrite_d = cmd_write_i;
        paddr_d  = cmd_addr_i;
        pwdata_d = cmd_wdata_i;
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
        cnt_d   = '0;
      end
      ACCESS: if (pready_i || expire) begin
        state_d  = IDLE;
        psel_d   = 1'b0;
        pen_d    = 1'b0;
        rvalid_d = 1'b1;
        rerr_d   = pready_i ? pslverror_i : 1'b1;
        rdata_d  = (pready_i && !pwrite_q) ? prdata_i : '0;
      end else begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
        psel_d  = 1'b0;
        pen_d   = 1'b0;
      end
    endcase
  end
  // State and registered outputs; reset drops the bus at once and discards any in-flight transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed bench with an APB memory slave model and a response scoreboard
module tb_apb_master_bridge;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        pselx, penable, pwrite, pready, pslverror;
  logic [31:0] paddr, pwdata, prdata;
  int          checks = 0, errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic [31:0] mem [0:2047];
  int          wcnt = 0, wait_n = 0;
  logic        stuck = 1'b0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .pselx_o(pselx), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverror_i(pslverror)
  );

  always #5 clk = ~clk;

  // 2048-word memory slave with programmable wait states and an out-of-range error
  assign pready    = penable && !stuck && (wcnt >= wait_n);
  assign prdata    = (paddr < 32'd2048) ? mem[paddr[10:0]] : 32'hBAD0BAD0;
  assign pslverror = pselx && penable && (paddr >= 32'd2048);
  always @(posedge clk) begin
    wcnt <= (penable && !pready) ? wcnt + 1 : 0;
    if (pselx && penable && pready && pwrite && paddr < 32'd2048) mem[paddr[10:0]] <= pwdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (rst_ni && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        chk("rsp_error", 64'(rsp_error), 64'(e[32]));
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic push, input logic [31:0] er, input logic ee);
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    if (push) exp_q.push_back({ee, er});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("rsp_arrived", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outputs", 64'({pselx, penable, pwrite, rsp_valid, rsp_error}), 64'd0);
    chk("rst_buses", 64'(paddr | pwdata | rsp_rdata), 64'd0);
    @(negedge clk); rst_ni = 1'b1;
    // 1: zero-wait write, cycle-exact latency
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    chk("t1_setup_psel", 64'({pselx, penable, cmd_ready}), 64'b100);
    chk("t1_setup_addr", 64'(paddr), 64'h10);
    chk("t1_setup_wdata", 64'(pwdata), 64'hDEADBEEF);
    @(posedge clk); #1;
    chk("t1_access", 64'({pselx, penable, pwrite, rsp_valid}), 64'b1110);
    @(posedge clk); #1;
    chk("t1_rsp", 64'({rsp_valid, pselx, penable, cmd_ready}), 64'b1001);
    // 2: read back
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("t2_setup_pwrite", 64'(pwrite), 64'd0);
    @(posedge clk); #1;
    chk("t2_access_pwrite", 64'({penable, pwrite}), 64'b10);
    @(posedge clk); #1;
    chk("t2_rsp", 64'(rsp_valid), 64'd1);
    // 3: out-of-range write gets a slave error
    issue(1'b1, 32'h800, 32'h55AA55AA, 1'b1, 32'h0, 1'b1);
    wait_rsp();
    @(posedge clk); #1;
    chk("t3_pulse_one_cycle", 64'(rsp_valid), 64'd0);
    // 4: three wait states, bus held stable
    wait_n = 3;
    issue(1'b1, 32'h20, 32'h12345678, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_ctl", 64'({pselx, penable, pwrite, rsp_valid}), 64'b1110);
      chk("t4_hold_addr", 64'(paddr), 64'h20);
      chk("t4_hold_wdata", 64'(pwdata), 64'h12345678);
    end
    @(posedge clk); #1;
    chk("t4_rsp", 64'(rsp_valid), 64'd1);
    wait_n = 0;
    issue(1'b0, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0);
    wait_rsp();
    // 5: hung slave hits the 16-cycle timeout
    stuck = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
    repeat (16) begin
      @(posedge clk); #1;
    end
    chk("t5_still_waiting", 64'({pselx, penable, rsp_valid}), 64'b110);
    @(posedge clk); #1;
    chk("t5_abort", 64'({rsp_valid, rsp_error, pselx, penable, cmd_ready}), 64'b11001);
    chk("t5_rdata_zero", 64'(rsp_rdata), 64'd0);
    // 6: reset during ACCESS drops the bus and produces no response
    issue(1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_drop", 64'({pselx, penable, rsp_valid, cmd_ready}), 64'b0001);
    @(negedge clk); rst_ni = 1'b1; stuck = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    wait_rsp();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
